data_mem_pl: RTL and testbench

Parametrised, handshaked successor to the 16-bit data memory in the MEM stage of the pipelined MIPS. It adds configurable width, depth and read latency, per-byte write enables, an out-of-range error flag, and an optional hardware clear-on-reset sequence. It sits between the EX/MEM pipeline register and the MEM/WB register, and stalls the pipeline through `req_ready` while it initialises.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 40 ++++
 rtl/data_mem_pl.sv | 157 +++++++++++++++
 tb/tb_data_mem_pl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory: FSM states, lane count and the
// read-latency legality limits.
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dmem_state_t;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  function automatic int unsigned be_width(int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic bit read_lat_ok(int unsigned lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_W storage: synchronous read, byte-lane synchronous write, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [be_width(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata
);

  localparam int unsigned BeW = be_width(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Caller guarantees addr < DEPTH whenever en is high.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BeW; i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_pl.sv
// MEM-stage data memory with request/response handshake, optional clear-on-reset sequence,
// range checking and 1- or 2-cycle read latency.
module data_mem_pl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [be_width(DATA_W)-1:0] req_be,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_err,
  output logic                        init_done
);

  localparam int unsigned BeW = be_width(DATA_W);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("data_mem_pl: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("data_mem_pl: DATA_W must be a multiple of 8");
  end

  dmem_state_t       state_q;
  logic [ADDR_W-1:0] cnt_q;

  // Clear counter walks 0..DEPTH-1; ready/init_done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!CLEAR_ON_RESET || (cnt_q == LastAddr)) begin
            state_q   <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        ST_RUN: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: begin
          state_q   <= ST_INIT;
          req_ready <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  logic              clr_en;
  logic              accept;
  logic              in_range;
  logic              arr_en;
  logic              arr_we;
  logic [BeW-1:0]    arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  // The shared port belongs to the clear sequence during init, to requests afterwards.
  always_comb begin
    clr_en   = rst_n && (state_q == ST_INIT) && CLEAR_ON_RESET;
    accept   = rst_n && req_valid && req_ready;
    in_range = {1'b0, req_addr} < DepthLim;
    if (clr_en) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = cnt_q;
      arr_wdata = '0;
    end else begin
      arr_en    = accept && in_range && (!req_we || (req_be != '0));
      arr_we    = req_we;
      arr_be    = req_be;
      arr_addr  = req_addr;
      arr_wdata = req_wdata;
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .be   (arr_be),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  logic              ld_q;
  logic              ld_err_q;
  logic [DATA_W-1:0] ld_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q     <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      ld_q     <= accept && !req_we;
      ld_err_q <= accept && !req_we && !in_range;
    end
  end

  // The array output register is not reset and holds stale words, so mask it here.
  assign ld_data = (ld_q && !ld_err_q) ? arr_rdata : '0;

  if (READ_LAT == READ_LAT_MAX) begin : g_out_reg
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= ld_q;
        err_q   <= ld_err_q;
        data_q  <= ld_data;
      end
    end

    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = data_q;
  end else begin : g_direct
    assign resp_valid = ld_q;
    assign resp_err   = ld_err_q;
    assign resp_rdata = ld_data;
  end

endmodule

// File: tb/tb_data_mem_pl.sv
// Bench for data_mem_pl: three configurations share one request stream; a cycle-level
// reference model scores two of them every cycle, plus directed vectors and corner sequences.
module tb_data_mem_pl;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_we;
  logic [7:0]        req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic [2:0]        rdy;
  logic [2:0]        idone;
  logic [2:0]        rv;
  logic [2:0]        rerr;
  logic [2:0][15:0]  rdata;

  data_mem_pl #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(rv[0]),
    .resp_rdata(rdata[0]), .resp_err(rerr[0]), .init_done(idone[0])
  );

  data_mem_pl #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(200), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(rv[1]),
    .resp_rdata(rdata[1]), .resp_err(rerr[1]), .init_done(idone[1])
  );

  data_mem_pl #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(1), .CLEAR_ON_RESET(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(rv[2]),
    .resp_rdata(rdata[2]), .resp_err(rerr[2]), .init_done(idone[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  bit          started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: memory image, ready flag and a due-cycle response schedule per config.
  typedef struct packed {
    logic        v;
    logic        err;
    logic [15:0] d;
  } resp_t;

  int unsigned depth_m [2] = '{256, 200};
  int unsigned lat_m   [2] = '{1, 2};
  logic [15:0] mmem    [2][256];
  resp_t       sched   [2][4];
  logic        mrdy    [2];
  int unsigned edges   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      mrdy[k]  = 1'b0;
      edges[k] = 0;
      for (int s = 0; s < 4; s++) sched[k][s] = '0;
      for (int a = 0; a < 256; a++) mmem[k][a] = '0;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        edges[k] = 0;
        mrdy[k]  = 1'b0;
        for (int s = 0; s < 4; s++) sched[k][s] = '0;
      end else begin
        if (mrdy[k] && req_valid) begin
          int unsigned a;
          a = req_addr;
          if (req_we) begin
            if (a < depth_m[k]) begin
              for (int b = 0; b < 2; b++)
                if (req_be[b]) mmem[k][a][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end else if (a < depth_m[k]) begin
            sched[k][(cyc + lat_m[k] - 1) % 4] = {1'b1, 1'b0, mmem[k][a]};
          end else begin
            sched[k][(cyc + lat_m[k] - 1) % 4] = {1'b1, 1'b1, 16'h0000};
          end
        end
        if (!mrdy[k]) begin
          edges[k]++;
          if (edges[k] == depth_m[k]) begin
            mrdy[k] = 1'b1;
            for (int a = 0; a < 256; a++) mmem[k][a] = '0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        resp_t e;
        e = sched[k][cyc % 4];
        check($sformatf("sb%0d", k), {rdy[k], idone[k], rv[k], rerr[k], rdata[k]},
              {mrdy[k], mrdy[k], e.v, e.err, e.d});
        sched[k][cyc % 4] = '0;
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic drive(input logic we, input logic [7:0] a, input logic [15:0] wd,
                       input logic [1:0] be);
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [7:0] a, input logic [15:0] e0,
                          input logic r0, input logic [15:0] e1, input logic r1);
    bit          seen [2];
    int unsigned at   [2];
    logic [15:0] d    [2];
    logic        er   [2];
    for (int k = 0; k < 2; k++) begin
      seen[k] = 1'b0; at[k] = 0; d[k] = '0; er[k] = 1'b0;
    end
    drive(1'b0, a, 16'h0000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!seen[k] && rv[k]) begin
          seen[k] = 1'b1; at[k] = i; d[k] = rdata[k]; er[k] = rerr[k];
        end
      end
      if (i < 3) @(negedge clk);
    end
    check({name, "_d0"}, {seen[0], 8'(at[0]), er[0], d[0]}, {1'b1, 8'd0, r0, e0});
    check({name, "_d1"}, {seen[1], 8'(at[1]), er[1], d[1]}, {1'b1, 8'd1, r1, e1});
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] e0;
    logic        r0;
    logic [15:0] e1;
    logic        r1;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned nk [3];
    bit          got [3];
    int unsigned cnt [2];
    logic [15:0] dat [2][3];
    int unsigned atj [2][3];

    tbl[0]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 8'h7F, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b1};
    tbl[3]  = '{1'b1, 8'h07, 16'h1122, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 8'h07, 16'h0000, 2'b00, 16'h1122, 1'b0, 16'h1122, 1'b0};
    tbl[5]  = '{1'b1, 8'h07, 16'hAABB, 2'b01, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 8'h07, 16'h0000, 2'b00, 16'h11BB, 1'b0, 16'h11BB, 1'b0};
    tbl[7]  = '{1'b1, 8'h07, 16'h77CC, 2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 8'h07, 16'h0000, 2'b00, 16'h77BB, 1'b0, 16'h77BB, 1'b0};
    tbl[9]  = '{1'b1, 8'hFA, 16'h5A5A, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[10] = '{1'b0, 8'hFA, 16'h0000, 2'b00, 16'h5A5A, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{1'b1, 8'hC7, 16'hBEEF, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 8'hC7, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
    tbl[13] = '{1'b1, 8'hC8, 16'h1357, 2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 8'hC8, 16'h0000, 2'b00, 16'h1357, 1'b0, 16'h0000, 1'b1};
    tbl[15] = '{1'b1, 8'h03, 16'h1234, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[16] = '{1'b0, 8'h03, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[17] = '{1'b1, 8'hFF, 16'hCAFE, 2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[18] = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'hCA00, 1'b0, 16'h0000, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk);

    // Release reset; random requests during init must be ignored.
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin got[k] = 1'b0; nk[k] = 0; end
    while (!(got[0] && got[1] && got[2]) && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (!got[k] && rdy[k]) begin got[k] = 1'b1; nk[k] = n; end
      if (!got[1]) begin
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom_range(0, 255));
        req_wdata = 16'($urandom);
        req_be    = 2'($urandom_range(0, 3));
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("ready_edges_dut0", 64'(nk[0]), 64'd256);
    check("ready_edges_dut1", 64'(nk[1]), 64'd200);
    check("ready_edges_dut2", 64'(nk[2]), 64'd1);
    check("init_done_dut2", {rdy[2], idone[2]}, 2'b11);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].we) drive(1'b1, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      else load_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].e0, tbl[i].r0,
                    tbl[i].e1, tbl[i].r1);
    end

    // Back-to-back loads at 1, 2, 3: three consecutive responses in order.
    drive(1'b1, 8'd1, 16'h0101, 2'b11);
    drive(1'b1, 8'd2, 16'h0202, 2'b11);
    drive(1'b1, 8'd3, 16'h0303, 2'b11);
    cnt[0] = 0; cnt[1] = 0;
    for (int j = 0; j < 7; j++) begin
      if (j < 3) begin
        req_we = 1'b0; req_addr = 8'(j + 1); req_be = 2'b00; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          if (cnt[k] < 3) begin dat[k][cnt[k]] = rdata[k]; atj[k][cnt[k]] = j; end
          cnt[k]++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("b2b_count%0d", k), 64'(cnt[k]), 64'd3);
      for (int i = 0; i < 3; i++) begin
        if (i < int'(cnt[k]))
          check($sformatf("b2b%0d_%0d", k, i), {8'(atj[k][i]), dat[k][i]},
                {8'(i + int'(lat_m[k]) - 1), 8'(i + 1), 8'(i + 1)});
      end
    end

    // Randomised traffic scored by the model.
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15))
                                              : 8'($urandom_range(0, 255));
      req_wdata = 16'($urandom);
      req_be    = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    req_valid = 1'b0;

    // Load in flight, then reset on the following edge: nothing may emerge afterwards.
    drive(1'b1, 8'd7, 16'h7777, 2'b11);
    req_we = 1'b0; req_addr = 8'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("rst_no_resp%0d", j), {rv[1], rv[0]}, 2'b00);
    end
    rst_n = 1'b1;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reinit_ready", {rdy[1], rdy[0]}, 2'b11);
    load_chk("after_reset7", 8'd7, 16'h0000, 1'b0, 16'h0000, 1'b0);
    load_chk("after_resetFA", 8'hFA, 16'h0000, 1'b0, 16'h0000, 1'b1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
